// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared ALU widths, op codes and
// reservation station defaults.
package alu_rs_pkg;

  localparam int XLEN              = 32;
  localparam int ALU_OP_WIDTH      = 4;
  localparam int RS_SIZE_DEFAULT   = 8;
  localparam int ROB_WIDTH_DEFAULT = 4;

  typedef logic [XLEN-1:0]         xlen_t;
  typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 4'h1;
  localparam alu_op_t ALU_SUB = 4'h2;
  localparam alu_op_t ALU_AND = 4'h3;
  localparam alu_op_t ALU_OR  = 4'h4;
  localparam alu_op_t ALU_XOR = 4'h5;
  localparam alu_op_t ALU_SLT = 4'h6;
  localparam alu_op_t ALU_SLL = 4'h7;
  localparam alu_op_t ALU_SRL = 4'h8;
  localparam alu_op_t ALU_SRA = 4'h9;

endpackage

// File: rtl/alu_rs_pick.sv
// alu_rs_pick: lowest-index priority encoder.
// Returns the first set bit and a found flag.
module alu_rs_pick #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station and issue select.
// Option: ALU_RS_WAKEUP_BYPASS_EN issues in the wakeup cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE   = RS_SIZE_DEFAULT,
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 dispatch_valid,
  input  logic [ALU_OP_WIDTH-1:0] dispatch_op,
  input  logic [ROB_WIDTH-1:0] dispatch_rob_id,
  input  logic [XLEN-1:0]      dispatch_val_1,
  input  logic [XLEN-1:0]      dispatch_val_2,
  input  logic                 dispatch_dep_1,
  input  logic                 dispatch_dep_2,
  input  logic [ROB_WIDTH-1:0] dispatch_tag_1,
  input  logic [ROB_WIDTH-1:0] dispatch_tag_2,
  input  logic                 cdb0_valid,
  input  logic [ROB_WIDTH-1:0] cdb0_rob_id,
  input  logic [XLEN-1:0]      cdb0_value,
  input  logic                 cdb1_valid,
  input  logic [ROB_WIDTH-1:0] cdb1_rob_id,
  input  logic [XLEN-1:0]      cdb1_value,
  output logic                 full,
  output logic                 rs_ready,
  output logic [ALU_OP_WIDTH-1:0] rs_op,
  output logic [XLEN-1:0]      rs_val_1,
  output logic [XLEN-1:0]      rs_val_2,
  output logic [ROB_WIDTH-1:0] alu_rob_id
);

  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CW = IW + 1;

  typedef logic [ROB_WIDTH-1:0] rob_t;

  logic [RS_SIZE-1:0] vld_q, vld_d;
  logic [RS_SIZE-1:0] dep1_q, dep1_d;
  logic [RS_SIZE-1:0] dep2_q, dep2_d;
  alu_op_t op_q   [RS_SIZE];
  alu_op_t op_d   [RS_SIZE];
  rob_t    rob_q  [RS_SIZE];
  rob_t    rob_d  [RS_SIZE];
  rob_t    tag1_q [RS_SIZE];
  rob_t    tag1_d [RS_SIZE];
  rob_t    tag2_q [RS_SIZE];
  rob_t    tag2_d [RS_SIZE];
  xlen_t   v1_q   [RS_SIZE];
  xlen_t   v1_d   [RS_SIZE];
  xlen_t   v2_q   [RS_SIZE];
  xlen_t   v2_d   [RS_SIZE];

  logic [RS_SIZE-1:0] w1, w2, elig;
  xlen_t   wv1 [RS_SIZE];
  xlen_t   wv2 [RS_SIZE];

  logic          dd1, dd2;
  xlen_t         dv1, dv2;
  logic [IW-1:0] free_idx, iss_idx;
  logic          free_ok, iss_ok;
  logic [CW-1:0] cnt;

  logic    full_q, full_d;
  logic    rdy_q, rdy_d;
  alu_op_t rop_q, rop_d;
  xlen_t   rv1_q, rv1_d, rv2_q, rv2_d;
  rob_t    irob_q, irob_d;
  rob_t    arob_q, arob_d;

  // CDB match per entry operand; cdb0 overrides cdb1.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w1[i]  = 1'b0;
      w2[i]  = 1'b0;
      wv1[i] = v1_q[i];
      wv2[i] = v2_q[i];
      if (dep1_q[i] && cdb1_valid
          && tag1_q[i] == cdb1_rob_id) begin
        w1[i]  = 1'b1;
        wv1[i] = cdb1_value;
      end
      if (dep1_q[i] && cdb0_valid
          && tag1_q[i] == cdb0_rob_id) begin
        w1[i]  = 1'b1;
        wv1[i] = cdb0_value;
      end
      if (dep2_q[i] && cdb1_valid
          && tag2_q[i] == cdb1_rob_id) begin
        w2[i]  = 1'b1;
        wv2[i] = cdb1_value;
      end
      if (dep2_q[i] && cdb0_valid
          && tag2_q[i] == cdb0_rob_id) begin
        w2[i]  = 1'b1;
        wv2[i] = cdb0_value;
      end
    end
  end

`ifdef ALU_RS_WAKEUP_BYPASS_EN
  assign elig = vld_q & (~dep1_q | w1) & (~dep2_q | w2);
`else
  assign elig = vld_q & ~dep1_q & ~dep2_q;
`endif

  alu_rs_pick #(.N(RS_SIZE)) u_free (
    .req_i   (~vld_q),
    .idx_o   (free_idx),
    .found_o (free_ok)
  );

  alu_rs_pick #(.N(RS_SIZE)) u_iss (
    .req_i   (elig),
    .idx_o   (iss_idx),
    .found_o (iss_ok)
  );

  // Dispatch operands can be satisfied by a same-cycle CDB.
  always_comb begin
    dd1 = dispatch_dep_1;
    dv1 = dispatch_val_1;
    dd2 = dispatch_dep_2;
    dv2 = dispatch_val_2;
    if (dispatch_dep_1 && cdb1_valid
        && dispatch_tag_1 == cdb1_rob_id) begin
      dd1 = 1'b0;
      dv1 = cdb1_value;
    end
    if (dispatch_dep_1 && cdb0_valid
        && dispatch_tag_1 == cdb0_rob_id) begin
      dd1 = 1'b0;
      dv1 = cdb0_value;
    end
    if (dispatch_dep_2 && cdb1_valid
        && dispatch_tag_2 == cdb1_rob_id) begin
      dd2 = 1'b0;
      dv2 = cdb1_value;
    end
    if (dispatch_dep_2 && cdb0_valid
        && dispatch_tag_2 == cdb0_rob_id) begin
      dd2 = 1'b0;
      dv2 = cdb0_value;
    end
  end

  // Entry next state: wakeup, issue free, dispatch write.
  always_comb begin
    vld_d  = vld_q;
    op_d   = op_q;
    rob_d  = rob_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    dep1_d = dep1_q & ~w1;
    dep2_d = dep2_q & ~w2;
    v1_d   = wv1;
    v2_d   = wv2;
    if (iss_ok) vld_d[iss_idx] = 1'b0;
    if (dispatch_valid && !full_q && free_ok) begin
      vld_d[free_idx]  = 1'b1;
      op_d[free_idx]   = dispatch_op;
      rob_d[free_idx]  = dispatch_rob_id;
      tag1_d[free_idx] = dispatch_tag_1;
      tag2_d[free_idx] = dispatch_tag_2;
      dep1_d[free_idx] = dd1;
      dep2_d[free_idx] = dd2;
      v1_d[free_idx]   = dv1;
      v2_d[free_idx]   = dv2;
    end
    cnt = '0;
    for (int i = 0; i < RS_SIZE; i++)
      cnt = cnt + CW'(vld_d[i]);
    full_d = (cnt == CW'(RS_SIZE));
  end

  // Issue outputs; data holds when nothing issues.
  always_comb begin
    rdy_d  = iss_ok;
    rop_d  = iss_ok ? op_q[iss_idx]  : rop_q;
    rv1_d  = iss_ok ? wv1[iss_idx]   : rv1_q;
    rv2_d  = iss_ok ? wv2[iss_idx]   : rv2_q;
    irob_d = iss_ok ? rob_q[iss_idx] : irob_q;
    arob_d = rdy_q ? irob_q : arob_q;
  end

  // Control and output registers; flush acts as reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q  <= '0;
      full_q <= 1'b0;
      rdy_q  <= 1'b0;
      rop_q  <= '0;
      rv1_q  <= '0;
      rv2_q  <= '0;
      irob_q <= '0;
      arob_q <= '0;
    end else begin
      vld_q  <= vld_d;
      full_q <= full_d;
      rdy_q  <= rdy_d;
      rop_q  <= rop_d;
      rv1_q  <= rv1_d;
      rv2_q  <= rv2_d;
      irob_q <= irob_d;
      arob_q <= arob_d;
    end
  end

  // Entry payload; only meaningful while valid.
  always_ff @(posedge clk) begin
    dep1_q <= dep1_d;
    dep2_q <= dep2_d;
    op_q   <= op_d;
    rob_q  <= rob_d;
    tag1_q <= tag1_d;
    tag2_q <= tag2_d;
    v1_q   <= v1_d;
    v2_q   <= v2_d;
  end

  assign full       = full_q;
  assign rs_ready   = rdy_q;
  assign rs_op      = rop_q;
  assign rs_val_1   = rv1_q;
  assign rs_val_2   = rv2_q;
  assign alu_rob_id = arob_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed self-checking bench for alu_rs.
// Follows ALU_RS_WAKEUP_BYPASS_EN when it is defined.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, dispatch_valid;
  alu_op_t dispatch_op;
  logic [3:0] dispatch_rob_id, dispatch_tag_1, dispatch_tag_2;
  xlen_t dispatch_val_1, dispatch_val_2;
  logic dispatch_dep_1, dispatch_dep_2;
  logic cdb0_valid, cdb1_valid;
  logic [3:0] cdb0_rob_id, cdb1_rob_id;
  xlen_t cdb0_value, cdb1_value;
  logic full, rs_ready;
  alu_op_t rs_op;
  xlen_t rs_val_1, rs_val_2;
  logic [3:0] alu_rob_id;

  int checks = 0;
  int failures = 0;

  alu_rs #(.RS_SIZE(8), .ROB_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid),
    .dispatch_op(dispatch_op),
    .dispatch_rob_id(dispatch_rob_id),
    .dispatch_val_1(dispatch_val_1),
    .dispatch_val_2(dispatch_val_2),
    .dispatch_dep_1(dispatch_dep_1),
    .dispatch_dep_2(dispatch_dep_2),
    .dispatch_tag_1(dispatch_tag_1),
    .dispatch_tag_2(dispatch_tag_2),
    .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id),
    .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id),
    .cdb1_value(cdb1_value),
    .full(full), .rs_ready(rs_ready), .rs_op(rs_op),
    .rs_val_1(rs_val_1), .rs_val_2(rs_val_2),
    .alu_rob_id(alu_rob_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    assert (!(dispatch_valid && full && !rst && !flush))
      else $error("dispatch while full");

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    dispatch_op = '0;
    dispatch_rob_id = '0;
    dispatch_val_1 = '0;
    dispatch_val_2 = '0;
    dispatch_dep_1 = 1'b0;
    dispatch_dep_2 = 1'b0;
    dispatch_tag_1 = '0;
    dispatch_tag_2 = '0;
    cdb0_valid = 1'b0;
    cdb0_rob_id = '0;
    cdb0_value = '0;
    cdb1_valid = 1'b0;
    cdb1_rob_id = '0;
    cdb1_value = '0;
    flush = 1'b0;
  endtask

  task automatic disp(input alu_op_t op, input logic [3:0] rob,
                      input xlen_t a, input xlen_t b,
                      input logic d1, input logic d2,
                      input logic [3:0] t1, input logic [3:0] t2);
    dispatch_valid = 1'b1;
    dispatch_op = op;
    dispatch_rob_id = rob;
    dispatch_val_1 = a;
    dispatch_val_2 = b;
    dispatch_dep_1 = d1;
    dispatch_dep_2 = d2;
    dispatch_tag_1 = t1;
    dispatch_tag_2 = t2;
  endtask

  task automatic set_cdb0(input logic [3:0] id, input xlen_t v);
    cdb0_valid = 1'b1;
    cdb0_rob_id = id;
    cdb0_value = v;
  endtask

  task automatic set_cdb1(input logic [3:0] id, input xlen_t v);
    cdb1_valid = 1'b1;
    cdb1_rob_id = id;
    cdb1_value = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    checks++;
    if ({full, rs_ready, rs_op, rs_val_1, rs_val_2, alu_rob_id} !== 74'd0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0",
               {full, rs_ready, rs_op, rs_val_1, rs_val_2, alu_rob_id});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    disp(ALU_ADD, 4'd3, 32'd5, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    idle();
    checks++;
    if (rs_ready !== 1'b0) begin
      failures++;
      $display("FAIL add_not_yet rs_ready got=%b exp=0", rs_ready);
    end
    step();
    checks++;
    if ({rs_ready, rs_op, rs_val_1, rs_val_2} !== {1'b1, ALU_ADD, 32'd5, 32'd7}) begin
      failures++;
      $display("FAIL add_issue got=%b/%h/%0d/%0d exp=1/%h/5/7",
               rs_ready, rs_op, rs_val_1, rs_val_2, ALU_ADD);
    end
    step();
    checks++;
    if ({rs_ready, alu_rob_id} !== {1'b0, 4'd3}) begin
      failures++;
      $display("FAIL add_robid got=%b/%0d exp=0/3", rs_ready, alu_rob_id);
    end
  endtask

  task automatic test_wakeup();
    disp(ALU_SUB, 4'd4, 32'd0, 32'd20, 1'b1, 1'b0, 4'd2, 4'd0);
    step();
    idle();
    step();
    checks++;
    if (rs_ready !== 1'b0) begin
      failures++;
      $display("FAIL wake_early rs_ready got=%b exp=0", rs_ready);
    end
    set_cdb1(4'd2, 32'd100);
    step();
    idle();
`ifndef ALU_RS_WAKEUP_BYPASS_EN
    checks++;
    if (rs_ready !== 1'b0) begin
      failures++;
      $display("FAIL wake_same_edge rs_ready got=%b exp=0", rs_ready);
    end
    step();
`endif
    checks++;
    if ({rs_ready, rs_op, rs_val_1, rs_val_2} !== {1'b1, ALU_SUB, 32'd100, 32'd20}) begin
      failures++;
      $display("FAIL wake_issue got=%b/%h/%0d/%0d exp=1/%h/100/20",
               rs_ready, rs_op, rs_val_1, rs_val_2, ALU_SUB);
    end
    step();
    checks++;
    if ({rs_ready, alu_rob_id} !== {1'b0, 4'd4}) begin
      failures++;
      $display("FAIL wake_robid got=%b/%0d exp=0/4", rs_ready, alu_rob_id);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 8; k++) begin
      disp(ALU_ADD, 4'(k), 32'd0, 32'(k + 16), 1'b1, 1'b0, 4'd9, 4'd0);
      step();
      checks++;
      if (full !== (k == 7)) begin
        failures++;
        $display("FAIL fill_full k=%0d got=%b exp=%b", k, full, k == 7);
      end
    end
    idle();
    set_cdb0(4'd9, 32'd1);
    step();
    idle();
`ifndef ALU_RS_WAKEUP_BYPASS_EN
    checks++;
    if ({rs_ready, full} !== 2'b01) begin
      failures++;
      $display("FAIL fill_wake got=%b/%b exp=0/1", rs_ready, full);
    end
    step();
`endif
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({rs_ready, rs_val_1, rs_val_2, full} !== {1'b1, 32'd1, 32'(k + 16), 1'b0}) begin
        failures++;
        $display("FAIL fill_issue k=%0d got=%b/%0d/%0d/%b exp=1/1/%0d/0",
                 k, rs_ready, rs_val_1, rs_val_2, full, k + 16);
      end
      if (k > 0) begin
        checks++;
        if (alu_rob_id !== 4'(k - 1)) begin
          failures++;
          $display("FAIL fill_robid k=%0d got=%0d exp=%0d", k, alu_rob_id, k - 1);
        end
      end
      step();
    end
    checks++;
    if ({rs_ready, alu_rob_id} !== {1'b0, 4'd7}) begin
      failures++;
      $display("FAIL fill_drain got=%b/%0d exp=0/7", rs_ready, alu_rob_id);
    end
  endtask

  task automatic test_capture();
    disp(ALU_XOR, 4'd6, 32'd0, 32'd3, 1'b1, 1'b0, 4'd5, 4'd0);
    set_cdb0(4'd5, 32'hDEAD);
    step();
    idle();
    checks++;
    if (rs_ready !== 1'b0) begin
      failures++;
      $display("FAIL cap_not_yet rs_ready got=%b exp=0", rs_ready);
    end
    step();
    checks++;
    if ({rs_ready, rs_op, rs_val_1, rs_val_2} !== {1'b1, ALU_XOR, 32'hDEAD, 32'd3}) begin
      failures++;
      $display("FAIL cap_issue got=%b/%h/%h/%0d exp=1/%h/dead/3",
               rs_ready, rs_op, rs_val_1, rs_val_2, ALU_XOR);
    end
    step();
  endtask

  task automatic test_back_to_back();
    disp(ALU_AND, 4'd1, 32'd1, 32'd2, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    checks++;
    if (rs_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first rs_ready got=%b exp=0", rs_ready);
    end
    disp(ALU_OR, 4'd2, 32'd3, 32'd4, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    checks++;
    if ({rs_ready, rs_op, rs_val_1, rs_val_2} !== {1'b1, ALU_AND, 32'd1, 32'd2}) begin
      failures++;
      $display("FAIL b2b_a got=%b/%h/%0d/%0d exp=1/%h/1/2",
               rs_ready, rs_op, rs_val_1, rs_val_2, ALU_AND);
    end
    disp(ALU_SLT, 4'd3, 32'd5, 32'd6, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    idle();
    checks++;
    if ({rs_ready, rs_op, rs_val_1, rs_val_2, alu_rob_id} !== {1'b1, ALU_OR, 32'd3, 32'd4, 4'd1}) begin
      failures++;
      $display("FAIL b2b_b got=%b/%h/%0d/%0d/%0d exp=1/%h/3/4/1",
               rs_ready, rs_op, rs_val_1, rs_val_2, alu_rob_id, ALU_OR);
    end
    step();
    checks++;
    if ({rs_ready, rs_op, rs_val_1, rs_val_2, alu_rob_id} !== {1'b1, ALU_SLT, 32'd5, 32'd6, 4'd2}) begin
      failures++;
      $display("FAIL b2b_c got=%b/%h/%0d/%0d/%0d exp=1/%h/5/6/2",
               rs_ready, rs_op, rs_val_1, rs_val_2, alu_rob_id, ALU_SLT);
    end
    step();
    checks++;
    if ({rs_ready, alu_rob_id} !== {1'b0, 4'd3}) begin
      failures++;
      $display("FAIL b2b_end got=%b/%0d exp=0/3", rs_ready, alu_rob_id);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 7; k++) begin
      disp(ALU_ADD, 4'(k + 1), 32'd0, 32'(k), 1'b1, 1'b0,
           (k == 2 || k == 6) ? 4'd11 : 4'd10, 4'd0);
      step();
    end
    idle();
    set_cdb1(4'd11, 32'd77);
    step();
    idle();
    flush = 1'b1;
    disp(ALU_SUB, 4'd13, 32'd9, 32'd9, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    idle();
    checks++;
    if ({rs_ready, full, alu_rob_id} !== 6'd0) begin
      failures++;
      $display("FAIL flush_outs got=%b/%b/%0d exp=0/0/0", rs_ready, full, alu_rob_id);
    end
    step();
    checks++;
    if ({rs_ready, full, alu_rob_id} !== 6'd0) begin
      failures++;
      $display("FAIL flush_empty got=%b/%b/%0d exp=0/0/0", rs_ready, full, alu_rob_id);
    end
    set_cdb0(4'd10, 32'd1);
    set_cdb1(4'd11, 32'd2);
    step();
    idle();
    checks++;
    if (rs_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_wake0 rs_ready got=%b exp=0", rs_ready);
    end
    step();
    checks++;
    if (rs_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_wake1 rs_ready got=%b exp=0", rs_ready);
    end
  endtask

  task automatic test_reset_mid();
    disp(ALU_OR, 4'd5, 32'h11, 32'h22, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    disp(ALU_ADD, 4'd7, 32'd1, 32'd1, 1'b1, 1'b1, 4'd15, 4'd15);
    step();
    rst = 1'b1;
    disp(ALU_SUB, 4'd8, 32'd3, 32'd3, 1'b0, 1'b0, 4'd0, 4'd0);
    step();
    step();
    idle();
    checks++;
    if ({full, rs_ready, rs_op, rs_val_1, rs_val_2, alu_rob_id} !== 74'd0) begin
      failures++;
      $display("FAIL rst_mid_outs got=%h exp=0",
               {full, rs_ready, rs_op, rs_val_1, rs_val_2, alu_rob_id});
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      disp(ALU_AND, 4'(k + 8), 32'd0, 32'(k + 48), 1'b1, 1'b0, 4'd13, 4'd0);
      step();
      checks++;
      if (full !== (k == 7)) begin
        failures++;
        $display("FAIL rst_refill k=%0d got=%b exp=%b", k, full, k == 7);
      end
    end
    idle();
    set_cdb0(4'd13, 32'd5);
    step();
    idle();
`ifndef ALU_RS_WAKEUP_BYPASS_EN
    step();
`endif
    checks++;
    if ({rs_ready, rs_op, rs_val_1, rs_val_2} !== {1'b1, ALU_AND, 32'd5, 32'd48}) begin
      failures++;
      $display("FAIL rst_first_entry got=%b/%h/%0d/%0d exp=1/%h/5/48",
               rs_ready, rs_op, rs_val_1, rs_val_2, ALU_AND);
    end
    step();
    checks++;
    if ({rs_val_2, alu_rob_id} !== {32'd49, 4'd8}) begin
      failures++;
      $display("FAIL rst_second got=%0d/%0d exp=49/8", rs_val_2, alu_rob_id);
    end
    for (int k = 0; k < 8; k++) step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_wakeup();
    test_fill();
    test_capture();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
